fp_add_arbiter: RTL and testbench

- Shares one single-precision float adder among N_REQ requesters.
- Arbitrates requests round-robin and drives the adder's operand and valid inputs.
- Tracks in-flight operations in a tag pipeline matched to the adder latency.
- Returns each sum to its originating requester through a one-entry response buffer with valid/ready handshake; sits between compute clients and the shared adder.

---
 rtl/fp_add_pkg.sv | 23 ++
 rtl/rr_picker.sv | 34 +++
 rtl/fp_add_arbiter.sv | 140 ++++++++++++++
 tb/tb_fp_add_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared constants and types for the round-robin float-adder arbiter.
package fp_add_pkg;

  localparam int FP_W        = 32;
  localparam int SIGN_BIT    = 31;
  localparam int EXP_MSB     = 30;
  localparam int EXP_LSB     = 23;
  localparam int MANT_MSB    = 22;
  localparam int MANT_LSB    = 0;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_ADD_LAT = 1;
  localparam int MAX_N_REQ   = 8;

  // Tag index is sized for the largest supported requester count.
  localparam int TAG_IDX_W   = $clog2(MAX_N_REQ);

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first eligible index at or after the pointer.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_eligible,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW:0] w_cand;

  // Candidates are visited ptr, ptr+1, ... with wrap at N, which need not be a power of two.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(N)) begin
        w_cand = w_cand - (IW+1)'(N);
      end
      if (!o_any && i_eligible[w_cand[IW-1:0]]) begin
        o_any                   = 1'b1;
        o_grant[w_cand[IW-1:0]] = 1'b1;
        o_idx                   = w_cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one float adder among N_REQ requesters: round-robin grant, a tag pipeline
// matched to the adder latency, and a one-entry response buffer per requester.
module fp_add_arbiter
  import fp_add_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int ADD_LAT = DEF_ADD_LAT,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [FP_W*N_REQ-1:0] req_x,
  input  logic [FP_W*N_REQ-1:0] req_y,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [FP_W*N_REQ-1:0] rsp_data,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [FP_W-1:0]       add_x,
  output logic [FP_W-1:0]       add_y,
  output logic                  add_valid_x,
  output logic                  add_valid_y,
  input  logic [FP_W-1:0]       add_data,
  output logic [CNT_W-1:0]      ops_done,
  output logic                  idle
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]      r_busy;
  logic [N_REQ-1:0]      r_rspValid;
  logic [FP_W*N_REQ-1:0] r_rspData;
  logic [IDX_W-1:0]      r_rrPtr;
  logic [CNT_W-1:0]      r_opsDone;
  tag_t                  r_tag [ADD_LAT];

  logic [N_REQ-1:0]      w_eligible;
  logic [N_REQ-1:0]      w_grant;
  logic [IDX_W-1:0]      w_grantIdx;
  logic                  w_grantAny;
  logic [N_REQ-1:0]      w_handshake;
  logic [CNT_W-1:0]      w_hsCount;
  tag_t                  w_tagOut;

  // busy is purely registered, so grants never depend combinationally on rsp_ready.
  assign w_eligible  = req_valid & ~r_busy;
  assign w_handshake = r_rspValid & rsp_ready;
  assign w_tagOut    = r_tag[ADD_LAT-1];

  rr_picker #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_picker (
    .i_eligible (w_eligible),
    .i_ptr      (r_rrPtr),
    .o_grant    (w_grant),
    .o_idx      (w_grantIdx),
    .o_any      (w_grantAny)
  );

  always_comb begin
    add_x = '0;
    add_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        add_x = req_x[i*FP_W +: FP_W];
        add_y = req_y[i*FP_W +: FP_W];
      end
    end
  end

  always_comb begin
    w_hsCount = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_hsCount = w_hsCount + CNT_W'(w_handshake[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr <= '0;
    end else if (w_grantAny) begin
      r_rrPtr <= (w_grantIdx == IDX_W'(N_REQ-1)) ? '0 : w_grantIdx + 1'b1;
    end
  end

  // Completion timing comes only from this pipeline; the adder's own valid is unused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < ADD_LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_tag[0].valid <= w_grantAny;
      r_tag[0].idx   <= TAG_IDX_W'(w_grantIdx);
      for (int s = 1; s < ADD_LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_rspValid <= '0;
      r_rspData  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_handshake[i]) begin
          r_rspValid[i] <= 1'b0;
          r_busy[i]     <= 1'b0;
        end
        if (w_tagOut.valid && (w_tagOut.idx == TAG_IDX_W'(i))) begin
          r_rspValid[i]              <= 1'b1;
          r_rspData[i*FP_W +: FP_W]  <= add_data;
        end
        if (w_grant[i]) begin
          r_busy[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opsDone <= '0;
    end else begin
      r_opsDone <= r_opsDone + w_hsCount;
    end
  end

  assign req_ready   = w_grant;
  assign add_valid_x = w_grantAny;
  assign add_valid_y = w_grantAny;
  assign rsp_valid   = r_rspValid;
  assign rsp_data    = r_rspData;
  assign ops_done    = r_opsDone;
  assign idle        = ~|req_valid & ~|r_busy;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: a latency-1 float adder model, a per-cycle behavioural
// reference built from half-integer operand values, and directed literal checks.
module tb_fp_add_arbiter;
  import fp_add_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 1;
  localparam int CW  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [32*N-1:0] req_x, req_y, rsp_data;
  logic [31:0]     add_x, add_y;
  logic [31:0]     add_data = '0;
  logic            add_valid_x, add_valid_y, idle;
  logic [CW-1:0]   ops_done;

  int vectors = 0;
  int miscompares = 0;
  int xH[N];
  int yH[N];

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          left;
  } flight_t;

  logic [N-1:0] mBusy, mRspValid;
  logic [31:0]  mRspData[N];
  int           mPtr, mOps;
  flight_t      mFlight[$];

  fp_add_arbiter #(.N_REQ(N), .ADD_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .add_x(add_x), .add_y(add_y), .add_valid_x(add_valid_x), .add_valid_y(add_valid_y),
    .add_data(add_data), .ops_done(ops_done), .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[EXP_MSB:MANT_LSB] == 31'd0) begin
      d = {f[SIGN_BIT], 63'd0};
    end else begin
      e = 11'(int'(f[EXP_MSB:EXP_LSB]) + 896);
      d = {f[SIGN_BIT], e, f[MANT_MSB:MANT_LSB], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [7:0]  e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = 8'(int'(d[62:52]) - 896);
    return {d[63], e, d[51:29]};
  endfunction

  // Value v is in units of 0.5, so every operand and sum used here is exact in single precision.
  function automatic logic [31:0] h2f(input int v);
    int          m, p;
    logic [31:0] mant;
    if (v == 0) return 32'd0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int b = 0; b < 31; b++) if (m[b]) p = b;
    mant = 32'(m) << (23 - p);
    return {(v < 0), 8'(126 + p), mant[22:0]};
  endfunction

  always @(posedge clk) begin
    if (add_valid_x && add_valid_y) add_data <= r2f(f2r(add_x) + f2r(add_y));
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mBusy     = '0;
    mRspValid = '0;
    for (int i = 0; i < N; i++) mRspData[i] = '0;
    mPtr = 0;
    mOps = 0;
    mFlight.delete();
  endtask

  // Reference: predict this cycle's outputs, then advance the model across the coming edge.
  always @(negedge clk) begin
    int           g, c;
    logic [N-1:0] hs;
    logic [127:0] expData;
    flight_t      f;
    if (!rst_n) modelReset();
    g = -1;
    for (int k = 0; k < N; k++) begin
      c = (mPtr + k) % N;
      if (g < 0 && req_valid[c] && !mBusy[c]) g = c;
    end
    expData = '0;
    for (int i = 0; i < N; i++) expData[32*i +: 32] = mRspData[i];
    if (g < 0) begin
      checkOutput("req_ready", req_ready, 0);
      checkOutput("add_valid", {add_valid_x, add_valid_y}, 0);
      checkOutput("add_xy", {add_x, add_y}, 0);
    end else begin
      checkOutput("req_ready", req_ready, 128'(1) << g);
      checkOutput("add_valid", {add_valid_x, add_valid_y}, 2'b11);
      checkOutput("add_xy", {add_x, add_y}, {h2f(xH[g]), h2f(yH[g])});
    end
    checkOutput("rsp_valid", rsp_valid, mRspValid);
    checkOutput("rsp_data", rsp_data, expData);
    checkOutput("ops_done", ops_done, mOps);
    checkOutput("idle", idle, (req_valid == 0) && (mBusy == 0));
    if (rst_n) begin
      hs = mRspValid & rsp_ready;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          mRspValid[i] = 1'b0;
          mBusy[i]     = 1'b0;
          mOps         = (mOps + 1) % (1 << CW);
        end
      end
      for (int j = 0; j < mFlight.size(); j++) mFlight[j].left = mFlight[j].left - 1;
      while (mFlight.size() > 0 && mFlight[0].left == 0) begin
        f = mFlight.pop_front();
        mRspValid[f.idx] = 1'b1;
        mRspData[f.idx]  = f.data;
      end
      if (g >= 0) begin
        mBusy[g] = 1'b1;
        mPtr     = (g + 1) % N;
        f.idx    = g;
        f.data   = h2f(xH[g] + yH[g]);
        f.left   = LAT;
        mFlight.push_back(f);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveOperands();
    for (int i = 0; i < N; i++) begin
      req_x[32*i +: 32] = h2f(xH[i]);
      req_y[32*i +: 32] = h2f(yH[i]);
    end
  endtask

  task automatic setOp(input int i, input int x, input int y);
    xH[i] = x;
    yH[i] = y;
    driveOperands();
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      xH[i] = int'($urandom_range(0, 4000)) - 2000;
      yH[i] = int'($urandom_range(0, 4000)) - 2000;
    end
    driveOperands();
    req_valid = N'($urandom);
    rsp_ready = N'($urandom);
    rst_n     = ($urandom_range(0, 199) != 0);
  endtask

  task automatic resetDut();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic doOp(input int i, input int x, input int y, input logic [31:0] expSum);
    tick();
    setOp(i, x, y);
    req_valid = N'(1 << i);
    rsp_ready = '0;
    #1 checkOutput("op_grant", req_ready, 128'(1) << i);
    tick();
    req_valid = '0;
    #1 checkOutput("op_inflight", rsp_valid[i], 0);
    tick();
    #1;
    checkOutput("op_rsp_valid", rsp_valid[i], 1);
    checkOutput("op_rsp_data", rsp_data[32*i +: 32], expSum);
    rsp_ready = N'(1 << i);
    tick();
    rsp_ready = '0;
    #1 checkOutput("op_released", rsp_valid[i], 0);
  endtask

  initial begin
    int x, y;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      xH[i] = 0;
      yH[i] = 0;
    end
    driveOperands();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_ops_done", ops_done, 0);
    checkOutput("reset_idle", idle, 1);

    // 1.0 + 2.0
    doOp(0, 2, 4, 32'h40400000);
    checkOutput("single_ops_done", ops_done, 1);

    resetDut();
    tick();
    for (int i = 0; i < N; i++) setOp(i, 2 * i + 1, 3);
    req_valid = '1;
    rsp_ready = '1;
    for (int k = 0; k < 12; k++) begin
      #1 checkOutput("rr_order", req_ready, 128'(1) << (k % N));
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
    rsp_ready = '0;

    // 1.5 + 2.5 held under backpressure while requester 2 is still served
    tick();
    setOp(1, 3, 5);
    req_valid = 4'b0010;
    rsp_ready = 4'b1101;
    #1 checkOutput("bp_grant1", req_ready, 4'b0010);
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 3) begin
        setOp(2, 4, 4);
        req_valid = 4'b0110;
      end
      if (k == 4) req_valid = 4'b0010;
      #1;
      checkOutput("bp_req1_blocked", req_ready[1], 0);
      if (k >= 2) begin
        checkOutput("bp_rsp_valid1", rsp_valid[1], 1);
        checkOutput("bp_rsp_data1", rsp_data[63:32], 32'h40800000);
      end
      if (k == 3) checkOutput("bp_grant2", req_ready, 4'b0100);
    end
    tick();
    req_valid = '0;
    rsp_ready = '1;
    repeat (3) tick();
    rsp_ready = '0;

    doOp(3, 6, -2, 32'h40000000);
    doOp(3, 4, -4, 32'h00000000);

    tick();
    setOp(0, 2, 4);
    req_valid = 4'b0001;
    #1 checkOutput("rst_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_ops_done", ops_done, 0);
    checkOutput("rst_idle", idle, 1);
    tick();
    tick();
    #1 checkOutput("rst_discarded", rsp_valid, 0);
    // 5.0 + 6.0
    doOp(2, 10, 12, 32'h41300000);

    resetDut();
    for (int n = 0; n < 17; n++) begin
      x = int'($urandom_range(0, 400)) - 200;
      y = int'($urandom_range(0, 400)) - 200;
      doOp(n % N, x, y, h2f(x + y));
    end
    #1 checkOutput("wrap_ops_done", ops_done, 1);

    for (int c = 0; c < 3000; c++) begin
      tick();
      applyStimulus();
    end
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
